// File: rtl/bms_cc_sequencer.sv
// Coulomb-counter sequencer: calibrates the ADC zero-current offset, then emits a
// fixed-rate, offset-corrected current stream with rest detection and stale-ADC fault.
module bms_cc_sequencer #(
    parameter int TICK_DIV   = 1000,
    parameter int CAL_LOG2   = 4,
    parameter int REST_THR   = 50,
    parameter int REST_TICKS = 8,
    parameter int STALE_MAX  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               recal_i,
    input  logic               fault_clr_i,
    input  logic               adc_valid_i,
    input  logic signed [15:0] adc_data_i,
    output logic               cc_en_o,
    output logic signed [15:0] current_o,
    output logic signed [15:0] offset_o,
    output logic [1:0]         state_o,
    output logic               rest_o,
    output logic               fault_o
);
    localparam int AW = 16 + CAL_LOG2;
    localparam int CW = CAL_LOG2 + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STALE_MAX + 1);
    localparam int RW = $clog2(REST_TICKS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

    state_t             state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d, acc_sum;
    logic [CW-1:0]      cal_cnt_q, cal_cnt_d;
    logic signed [15:0] offset_q, offset_d, sample_q, sample_d, current_q, current_d;
    logic signed [15:0] samp_now, corr;
    logic signed [16:0] diff;
    logic [15:0]        mag;
    logic               fresh_q, fresh_d, fresh_now, tick;
    logic [TW-1:0]      tick_q, tick_d;
    logic [SW-1:0]      stale_q, stale_d;
    logic [RW-1:0]      rest_cnt_q, rest_cnt_d, rest_next;
    logic               cc_en_q, cc_en_d, rest_q, rest_d, fault_q, fault_d;

    // A sample landing on the tick cycle itself must be the one integrated.
    assign samp_now  = adc_valid_i ? adc_data_i : sample_q;
    assign fresh_now = fresh_q | adc_valid_i;
    assign tick      = (tick_q == TW'(TICK_DIV - 1));
    assign acc_sum   = acc_q + {{CAL_LOG2{adc_data_i[15]}}, adc_data_i};
    assign diff      = {samp_now[15], samp_now} - {offset_q[15], offset_q};
    assign corr      = (diff[16] != diff[15]) ? (diff[16] ? 16'sh8000 : 16'sh7fff) : diff[15:0];
    assign mag       = corr[15] ? ((corr == 16'sh8000) ? 16'h7fff : 16'(-corr)) : corr;
    assign rest_next = (mag >= 16'(REST_THR)) ? '0 :
                       (rest_cnt_q == RW'(REST_TICKS)) ? rest_cnt_q : rest_cnt_q + RW'(1);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cal_cnt_d  = cal_cnt_q;
        offset_d   = offset_q;
        sample_d   = sample_q;
        current_d  = current_q;
        fresh_d    = fresh_q;
        tick_d     = tick_q;
        stale_d    = stale_q;
        rest_cnt_d = rest_cnt_q;
        rest_d     = rest_q;
        fault_d    = fault_q;
        cc_en_d    = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = CAL;
                acc_d     = '0;
                cal_cnt_d = '0;
            end
            CAL: if (recal_i) begin
                acc_d     = '0;
                cal_cnt_d = '0;
            end else if (adc_valid_i) begin
                acc_d     = acc_sum;
                cal_cnt_d = cal_cnt_q + CW'(1);
                if (cal_cnt_q == CW'((1 << CAL_LOG2) - 1)) begin
                    // Dropping the low bits of a signed sum is a floor divide.
                    offset_d = acc_sum[AW-1:CAL_LOG2];
                    state_d  = RUN;
                    tick_d   = '0;
                    fresh_d  = 1'b0;
                    stale_d  = '0;
                end
            end
            RUN: begin
                sample_d = samp_now;
                fresh_d  = fresh_now;
                if (recal_i) begin
                    state_d    = CAL;
                    acc_d      = '0;
                    cal_cnt_d  = '0;
                    rest_cnt_d = '0;
                    rest_d     = 1'b0;
                    fresh_d    = 1'b0;
                end else if (tick) begin
                    tick_d = '0;
                    if (fresh_now) begin
                        current_d  = corr;
                        cc_en_d    = 1'b1;
                        fresh_d    = 1'b0;
                        stale_d    = '0;
                        rest_cnt_d = rest_next;
                        rest_d     = (rest_next == RW'(REST_TICKS));
                    end else if (stale_q == SW'(STALE_MAX - 1)) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        current_d  = '0;
                        rest_d     = 1'b0;
                        rest_cnt_d = '0;
                        stale_d    = '0;
                    end else begin
                        stale_d = stale_q + SW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            FAULT: if (fault_clr_i) begin
                state_d = IDLE;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cal_cnt_q  <= '0;
            offset_q   <= '0;
            sample_q   <= '0;
            current_q  <= '0;
            fresh_q    <= 1'b0;
            tick_q     <= '0;
            stale_q    <= '0;
            rest_cnt_q <= '0;
            rest_q     <= 1'b0;
            fault_q    <= 1'b0;
            cc_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cal_cnt_q  <= cal_cnt_d;
            offset_q   <= offset_d;
            sample_q   <= sample_d;
            current_q  <= current_d;
            fresh_q    <= fresh_d;
            tick_q     <= tick_d;
            stale_q    <= stale_d;
            rest_cnt_q <= rest_cnt_d;
            rest_q     <= rest_d;
            fault_q    <= fault_d;
            cc_en_q    <= cc_en_d;
        end
    end

    assign cc_en_o   = cc_en_q;
    assign current_o = current_q;
    assign offset_o  = offset_q;
    assign state_o   = state_q;
    assign rest_o    = rest_q;
    assign fault_o   = fault_q;
endmodule

// File: tb/tb_bms_cc_sequencer.sv
// Bench for bms_cc_sequencer: calibration vector table, hand-written corner
// sequences, then random stimulus against an integer-level reference model.
module tb_bms_cc_sequencer;
    localparam int TICK_DIV = 10, CAL_LOG2 = 2, REST_THR = 50, REST_TICKS = 3, STALE_MAX = 3;
    localparam int NCAL = 1 << CAL_LOG2;

    logic clk = 1'b0, rst = 1'b1;
    logic start_i = 0, recal_i = 0, fault_clr_i = 0, adc_valid_i = 0;
    logic signed [15:0] adc_data_i = '0;
    logic cc_en_o, rest_o, fault_o;
    logic signed [15:0] current_o, offset_o;
    logic [1:0] state_o;

    int n_cmp = 0, n_fail = 0;

    bms_cc_sequencer #(.TICK_DIV(TICK_DIV), .CAL_LOG2(CAL_LOG2), .REST_THR(REST_THR),
                       .REST_TICKS(REST_TICKS), .STALE_MAX(STALE_MAX)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .recal_i(recal_i), .fault_clr_i(fault_clr_i),
        .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i), .cc_en_o(cc_en_o),
        .current_o(current_o), .offset_o(offset_o), .state_o(state_o),
        .rest_o(rest_o), .fault_o(fault_o));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_i = 0; recal_i = 0; fault_clr_i = 0; adc_valid_i = 0; adc_data_i = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic calibrate(input bit use_recal, input int a, input int b, input int c, input int d);
        int s[4];
        s = '{a, b, c, d};
        if (use_recal) recal_i = 1'b1; else start_i = 1'b1;
        step();
        recal_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adc_valid_i = 1'b1;
            adc_data_i  = 16'(s[i]);
            step();
        end
        adc_valid_i = 1'b0;
    endtask

    // Runs one full tick period from an aligned phase; the sample (if any) arrives
    // either right at the start of the period or on the tick cycle itself.
    task automatic run_tick(input int data, input bit valid, input bit late, input string tag);
        if (valid && !late) begin adc_valid_i = 1'b1; adc_data_i = 16'(data); end
        step();
        adc_valid_i = 1'b0;
        for (int i = 1; i < TICK_DIV - 1; i++) step();
        check({tag, " cc_en before tick"}, int'(cc_en_o), 0);
        if (valid && late) begin adc_valid_i = 1'b1; adc_data_i = 16'(data); end
        step();
        adc_valid_i = 1'b0;
    endtask

    // Reference model: integer state, a queue for calibration samples, floor division.
    int m_state, m_off, m_samp, m_phase, m_stale, m_restn, m_cur;
    bit m_fresh, m_cc, m_rest, m_fault;
    int m_cal[$];

    task automatic model_reset();
        m_state = 0; m_off = 0; m_samp = 0; m_phase = 0; m_stale = 0; m_restn = 0; m_cur = 0;
        m_fresh = 0; m_cc = 0; m_rest = 0; m_fault = 0;
        m_cal.delete();
    endtask

    task automatic model_edge(input bit st, input bit rc, input bit fc, input bit v, input int d);
        int sum, mag;
        bit tk;
        m_cc = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_cal.delete(); end
            1: if (rc) m_cal.delete();
               else if (v) begin
                   m_cal.push_back(d);
                   if (m_cal.size() == NCAL) begin
                       sum = 0;
                       foreach (m_cal[i]) sum += m_cal[i];
                       m_off = (sum >= 0) ? sum / NCAL : -((-sum + NCAL - 1) / NCAL);
                       m_state = 2; m_phase = 0; m_fresh = 0; m_stale = 0;
                   end
               end
            2: begin
                tk = (m_phase % TICK_DIV) == TICK_DIV - 1;
                if (v) begin m_samp = d; m_fresh = 1; end
                if (rc) begin
                    m_state = 1; m_cal.delete(); m_restn = 0; m_rest = 0;
                end else begin
                    if (tk) begin
                        if (m_fresh) begin
                            m_cur = m_samp - m_off;
                            if (m_cur > 32767) m_cur = 32767;
                            if (m_cur < -32768) m_cur = -32768;
                            m_cc = 1; m_fresh = 0; m_stale = 0;
                            mag = (m_cur < 0) ? -m_cur : m_cur;
                            if (mag > 32767) mag = 32767;
                            m_restn = (mag < REST_THR) ? m_restn + 1 : 0;
                            m_rest = m_restn >= REST_TICKS;
                        end else begin
                            m_stale++;
                            if (m_stale >= STALE_MAX) begin
                                m_state = 3; m_fault = 1; m_cur = 0; m_rest = 0; m_restn = 0;
                            end
                        end
                    end
                    m_phase++;
                end
            end
            default: if (fc) begin m_state = 0; m_fault = 0; end
        endcase
    endtask

    typedef struct { int s0, s1, s2, s3, run, off, cur; } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{20, 21, 22, 23, 1021, 21, 1000};
        tbl[1] = '{-4, -4, -4, -4, 32767, -4, 32767};
        tbl[2] = '{100, 100, 100, 100, -32768, 100, -32768};
        tbl[3] = '{-1, -2, -2, -2, 0, -2, 2};
        tbl[4] = '{32767, 32767, 32767, 32767, -32768, 32767, -32768};

        do_reset();
        check("reset cc_en", int'(cc_en_o), 0);
        check("reset current", int'(current_o), 0);
        check("reset offset", int'(offset_o), 0);
        check("reset state", int'(state_o), 0);
        check("reset rest", int'(rest_o), 0);
        check("reset fault", int'(fault_o), 0);

        foreach (tbl[k]) begin
            do_reset();
            calibrate(0, tbl[k].s0, tbl[k].s1, tbl[k].s2, tbl[k].s3);
            check($sformatf("vec%0d offset", k), int'(offset_o), tbl[k].off);
            check($sformatf("vec%0d state", k), int'(state_o), 2);
            for (int p = 0; p < 2; p++) begin
                run_tick(tbl[k].run, 1, 0, $sformatf("vec%0d", k));
                check($sformatf("vec%0d cc_en tick%0d", k, p), int'(cc_en_o), 1);
                check($sformatf("vec%0d current tick%0d", k, p), int'(current_o), tbl[k].cur);
            end
        end

        // Rest detection
        do_reset();
        calibrate(0, 20, 21, 22, 23);
        for (int i = 0; i < 3; i++) begin
            run_tick(31, 1, 0, "rest");
            check($sformatf("rest cc_en %0d", i), int'(cc_en_o), 1);
            check($sformatf("rest flag %0d", i), int'(rest_o), (i == 2) ? 1 : 0);
        end
        run_tick(81, 1, 0, "rest break");
        check("rest break current", int'(current_o), 60);
        check("rest break flag", int'(rest_o), 0);

        // Stale fault
        for (int i = 0; i < 3; i++) begin
            run_tick(0, 0, 0, "stale");
            check($sformatf("stale cc_en %0d", i), int'(cc_en_o), 0);
        end
        check("fault flag", int'(fault_o), 1);
        check("fault state", int'(state_o), 3);
        check("fault current", int'(current_o), 0);
        check("fault rest", int'(rest_o), 0);
        fault_clr_i = 1'b1;
        step();
        fault_clr_i = 1'b0;
        check("fault clr state", int'(state_o), 0);
        check("fault clr flag", int'(fault_o), 0);
        check("fault clr offset", int'(offset_o), 21);

        // Stale count cleared by a fresh tick
        calibrate(0, 20, 21, 22, 23);
        run_tick(0, 0, 0, "nf miss1");
        run_tick(0, 0, 0, "nf miss2");
        run_tick(31, 1, 0, "nf fresh");
        run_tick(0, 0, 0, "nf miss3");
        run_tick(0, 0, 0, "nf miss4");
        check("no fault state", int'(state_o), 2);
        check("no fault flag", int'(fault_o), 0);

        // Sample on the tick cycle itself
        run_tick(1021, 1, 1, "late");
        check("late cc_en", int'(cc_en_o), 1);
        check("late current", int'(current_o), 1000);

        // recal on a tick with fresh data
        adc_valid_i = 1'b1; adc_data_i = 16'(500);
        step();
        adc_valid_i = 1'b0;
        for (int i = 1; i < TICK_DIV - 1; i++) step();
        recal_i = 1'b1;
        step();
        recal_i = 1'b0;
        check("recal cc_en", int'(cc_en_o), 0);
        check("recal state", int'(state_o), 1);
        check("recal current hold", int'(current_o), 1000);

        // Asynchronous reset during a cc_en pulse
        calibrate(1, 20, 21, 22, 23);
        run_tick(1021, 1, 0, "arst");
        check("arst pre cc_en", int'(cc_en_o), 1);
        #2 rst = 1'b1;
        #1;
        check("arst cc_en", int'(cc_en_o), 0);
        check("arst current", int'(current_o), 0);
        check("arst offset", int'(offset_o), 0);
        check("arst state", int'(state_o), 0);
        check("arst rest", int'(rest_o), 0);
        check("arst fault", int'(fault_o), 0);
        #3 rst = 1'b0;

        // Random stimulus against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 4500; c++) begin
            int vp, d;
            logic signed [15:0] r;
            vp = (c / 500 % 3 == 0) ? 500 : (c / 500 % 3 == 1) ? 30 : 3;
            start_i     = ($urandom_range(99) < 3);
            recal_i     = ($urandom_range(199) < 1);
            fault_clr_i = ($urandom_range(99) < 5);
            adc_valid_i = ($urandom_range(999) < vp);
            if ($urandom_range(9) == 0) begin
                r = 16'($urandom);
                d = int'(r);
            end else begin
                d = int'($urandom_range(200)) - 100;
            end
            adc_data_i = 16'(d);
            model_edge(start_i, recal_i, fault_clr_i, adc_valid_i, d);
            step();
            check($sformatf("rnd%0d state", c), int'(state_o), m_state);
            check($sformatf("rnd%0d cc_en", c), int'(cc_en_o), int'(m_cc));
            check($sformatf("rnd%0d current", c), int'(current_o), m_cur);
            check($sformatf("rnd%0d offset", c), int'(offset_o), m_off);
            check($sformatf("rnd%0d rest", c), int'(rest_o), int'(m_rest));
            check($sformatf("rnd%0d fault", c), int'(fault_o), int'(m_fault));
        end
        start_i = 0; recal_i = 0; fault_clr_i = 0; adc_valid_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
